contador_cascada: RTL and testbench

//  Synchronous up/down counter built from NUM_DIG cascaded digits, each modulo MODULO.
//  The default is two BCD digits, 00..99.

---
 rtl/contador_cascada_pkg.sv | 8 +
 rtl/contador_digito.sv | 31 +++
 rtl/contador_cascada.sv | 49 ++++
 tb/tb_contador_cascada.sv | 133 +++++++++++++
 4 files changed

// File: rtl/contador_cascada_pkg.sv
// contador_cascada_pkg: direction constants and digit-width helper shared by the counter slice
package contador_cascada_pkg;
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   function automatic int digit_width(input int modulo);
      return (modulo < 2) ? 1 : $clog2(modulo);
   endfunction
endpackage

// File: rtl/contador_digito.sv
// contador_digito: one modulo-MODULO up/down digit with clear, clamped load and step
module contador_digito
   import contador_cascada_pkg::*;
#(
   parameter int MODULO = 10,
   parameter int W      = digit_width(MODULO)
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         step_i,
   input  logic         up_i,
   output logic [W-1:0] val_o,
   output logic         term_o
);
   localparam logic [W-1:0] MAX = W'(MODULO - 1);
   logic [W-1:0] val_q, val_d;
   always_comb
      val_d = clr_i   ? '0 :
              load_i  ? ((load_val_i > MAX) ? MAX : load_val_i) :
              !step_i ? val_q :
              (up_i == DIR_UP) ? ((val_q == MAX) ? '0 : val_q + 1'b1)
                               : ((val_q == '0) ? MAX : val_q - 1'b1);
   always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) val_q <= '0;
      else       val_q <= val_d;
   assign val_o  = val_q;
   assign term_o = (up_i == DIR_DOWN) ? (val_q == '0) : (val_q == MAX);
endmodule

// File: rtl/contador_cascada.sv
// contador_cascada: NUM_DIG cascaded modulo-MODULO up/down digits with clear, load,
// direction-aware terminal count, cascade carry and a registered wrap pulse
module contador_cascada
   import contador_cascada_pkg::*;
#(
   parameter  int MODULO  = 10,
   parameter  int NUM_DIG = 2,
   localparam int W       = digit_width(MODULO)
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic               CLR,
   input  logic               LOAD,
   input  logic [NUM_DIG*W-1:0] LOAD_VAL,
   input  logic               ENABLE,
   input  logic               UP_DOWN,
   output logic [NUM_DIG*W-1:0] COUNT,
   output logic               TC,
   output logic               CARRY,
   output logic               WRAP
);
   logic [NUM_DIG-1:0] step, term;
   logic               wrap_q, wrap_d;
   assign step[0] = ENABLE & ~CLR & ~LOAD;
   for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
      // each digit's enable is a flat AND of all lower terminal flags
      if (i > 0) begin : g_step
         assign step[i] = step[0] & (&term[i-1:0]);
      end
      contador_digito #(.MODULO(MODULO), .W(W)) u_dig (
         .CLK        (CLK),
         .RSTn       (RSTn),
         .clr_i      (CLR),
         .load_i     (LOAD),
         .load_val_i (LOAD_VAL[i*W +: W]),
         .step_i     (step[i]),
         .up_i       (UP_DOWN),
         .val_o      (COUNT[i*W +: W]),
         .term_o     (term[i])
      );
   end
   assign TC     = &term;
   assign CARRY  = TC & ENABLE;
   assign wrap_d = step[0] & TC;
   always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) wrap_q <= 1'b0;
      else       wrap_q <= wrap_d;
   assign WRAP = wrap_q;
endmodule

// File: tb/tb_contador_cascada.sv
// tb_contador_cascada: directed and random checks of two counter instances (10x2 and 6x3)
// against an integer-valued reference model
module tb_contador_cascada;
   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic       clr_a = 0, load_a = 0, en_a = 0, ud_a = 1;
   logic [7:0] lv_a = '0, cnt_a;
   logic       tc_a, carry_a, wrap_a;
   logic       clr_b = 0, load_b = 0, en_b = 0, ud_b = 1;
   logic [8:0] lv_b = '0, cnt_b;
   logic       tc_b, carry_b, wrap_b;
   int nchk = 0, nfail = 0;
   int m[2] = '{0, 0};
   int wm[2] = '{0, 0};
   int modv[2] = '{10, 6};
   int ndv[2] = '{2, 3};
   int wv[2] = '{4, 3};

   always #5 CLK = ~CLK;

   contador_cascada #(.MODULO(10), .NUM_DIG(2)) dut_a (
      .CLK(CLK), .RSTn(RSTn), .CLR(clr_a), .LOAD(load_a), .LOAD_VAL(lv_a),
      .ENABLE(en_a), .UP_DOWN(ud_a), .COUNT(cnt_a), .TC(tc_a), .CARRY(carry_a), .WRAP(wrap_a));
   contador_cascada #(.MODULO(6), .NUM_DIG(3)) dut_b (
      .CLK(CLK), .RSTn(RSTn), .CLR(clr_b), .LOAD(load_b), .LOAD_VAL(lv_b),
      .ENABLE(en_b), .UP_DOWN(ud_b), .COUNT(cnt_b), .TC(tc_b), .CARRY(carry_b), .WRAP(wrap_b));

   function automatic int pw(input int b, input int e);
      int r = 1;
      for (int k = 0; k < e; k++) r *= b;
      return r;
   endfunction

   function automatic int clampv(input int lv, input int s);
      int r = 0;
      for (int k = 0; k < ndv[s]; k++) begin
         int d = (lv >> (k * wv[s])) & ((1 << wv[s]) - 1);
         if (d > modv[s] - 1) d = modv[s] - 1;
         r += d * pw(modv[s], k);
      end
      return r;
   endfunction

   function automatic int enc(input int v, input int s);
      int r = 0;
      for (int k = 0; k < ndv[s]; k++) begin
         r |= (v % modv[s]) << (k * wv[s]);
         v /= modv[s];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input int s, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, s, obs, exp);
      end
   endtask

   task automatic tick(input int s, input bit clr, input bit load, input int lv, input bit en, input bit ud);
      int n = pw(modv[s], ndv[s]);
      bit tc;
      if (s == 0) begin
         clr_a = clr; load_a = load; lv_a = 8'(lv); en_a = en; ud_a = ud;
         clr_b = 0; load_b = 0; en_b = 0;
      end else begin
         clr_b = clr; load_b = load; lv_b = 9'(lv); en_b = en; ud_b = ud;
         clr_a = 0; load_a = 0; en_a = 0;
      end
      #1;
      tc = ud ? (m[s] == n - 1) : (m[s] == 0);
      chk("tc", s, s ? tc_b : tc_a, tc);
      chk("carry", s, s ? carry_b : carry_a, tc & en);
      if (clr) begin m[s] = 0; wm[s] = 0; end
      else if (load) begin m[s] = clampv(lv, s); wm[s] = 0; end
      else if (en) begin wm[s] = tc; m[s] = ud ? (m[s] + 1) % n : (m[s] + n - 1) % n; end
      else wm[s] = 0;
      @(posedge CLK);
      #1;
      chk("count", s, s ? cnt_b : cnt_a, enc(m[s], s));
      chk("wrap", s, s ? wrap_b : wrap_a, wm[s]);
   endtask

   task automatic mid_reset();
      #2 RSTn = 1'b0;
      #1;
      chk("rst_count", 0, cnt_a, 0);
      chk("rst_wrap", 0, wrap_a, 0);
      chk("rst_count", 1, cnt_b, 0);
      chk("rst_wrap", 1, wrap_b, 0);
      m = '{0, 0};
      wm = '{0, 0};
      @(negedge CLK) RSTn = 1'b1;
   endtask

   initial begin
      #3;
      chk("rst_count", 0, cnt_a, 0);
      chk("rst_wrap", 0, wrap_a, 0);
      chk("rst_count", 1, cnt_b, 0);
      @(negedge CLK) RSTn = 1'b1;
      for (int k = 0; k < 100; k++) tick(0, 0, 0, 0, 1, 1);
      tick(0, 0, 1, 'h05, 0, 0);
      for (int k = 0; k < 6; k++) tick(0, 0, 0, 0, 1, 0);
      tick(0, 0, 1, 'hC3, 0, 1);
      tick(0, 1, 1, 'h47, 1, 1);
      tick(0, 0, 1, 'h39, 0, 1);
      tick(0, 0, 0, 0, 1, 1);
      tick(0, 0, 0, 0, 1, 0);
      tick(0, 0, 1, 'h00, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 1, 'h56, 0, 1);
      tick(0, 0, 0, 0, 1, 1);
      mid_reset();
      tick(0, 0, 1, 'h99, 0, 1);
      tick(0, 0, 0, 0, 1, 1);
      mid_reset();
      tick(1, 0, 1, 'h16D, 0, 1);
      tick(1, 0, 0, 0, 1, 1);
      tick(1, 0, 0, 0, 1, 1);
      tick(1, 0, 0, 0, 1, 0);
      tick(1, 0, 0, 0, 1, 0);
      for (int k = 0; k < 400; k++) begin
         int s = int'($urandom_range(0, 1));
         tick(s, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 511)), $urandom_range(0, 3) != 0, 1'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
